// File: rtl/access_rqst_gen_cfg_pipe.sv
// Share-group request flag generator: decodes every requestor's column address
// against the active mode and pipelines flags, popcount and overflow to the output.
module access_rqst_gen_cfg_pipe #(
  parameter int SHARED_BANK_NUM    = 5,
  parameter int RQST_ADDR_BITWIDTH = 3,
  parameter int MODE_BITWIDTH      = 3,
  parameter int PIPELINE_NUM       = 1,
  parameter int GP2_CAPACITY       = 2
) (
  input  logic                                          sys_clk,
  input  logic                                          rst,
  input  logic [RQST_ADDR_BITWIDTH*SHARED_BANK_NUM-1:0] rqst_addr_i,
  input  logic                                          rqst_valid_i,
  input  logic [MODE_BITWIDTH-1:0]                      modeSet_i,
  input  logic                                          mode_load_i,
  output logic [SHARED_BANK_NUM-1:0]                    share_rqstFlag_o,
  output logic [$clog2(SHARED_BANK_NUM+1)-1:0]          rqst_cnt_o,
  output logic                                          overflow_o,
  output logic                                          valid_o,
  output logic                                          mode_pending_o
);

  localparam int N     = SHARED_BANK_NUM;
  localparam int AW    = RQST_ADDR_BITWIDTH;
  localparam int CNT_W = $clog2(SHARED_BANK_NUM+1);

  function automatic logic decode_bit(input logic [AW-1:0] a,
                                      input logic [MODE_BITWIDTH-1:0] m);
    logic [31:0] mi;
    logic        hit;
    mi  = 32'(m);
    hit = 1'b0;
    case (mi)
      32'd0:   hit = ~a[1];
      32'd1:   hit = a[1];
      32'd2:   hit = ~a[0];
      32'd3:   hit = a[0];
      32'd4:   hit = a[1] ^ a[0];
      32'd5:   hit = ~(a[1] ^ a[0]);
      32'd6:   hit = ((a >> 2) == '0);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] f);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + CNT_W'(f[i]);
    return cnt;
  endfunction

  logic [MODE_BITWIDTH-1:0] active_mode;
  logic [MODE_BITWIDTH-1:0] pending_mode;
  logic [N-1:0]             dec_flags;
  logic [N-1:0]             flag_p [PIPELINE_NUM];
  logic [N-1:0]             flag_in [PIPELINE_NUM+1];
  logic [PIPELINE_NUM-1:0]  vld_p;
  logic [PIPELINE_NUM:0]    vld_in;
  logic                     drain;

  always_comb begin
    dec_flags = '0;
    for (int i = 0; i < N; i++)
      dec_flags[i] = rqst_valid_i & decode_bit(rqst_addr_i[i*AW +: AW], active_mode);
  end

  // Stage inputs: entry 0 is the freshly decoded vector, entry k feeds stage k.
  always_comb begin
    flag_in[0] = dec_flags;
    for (int i = 0; i < PIPELINE_NUM; i++) flag_in[i+1] = flag_p[i];
  end
  assign vld_in = {vld_p, rqst_valid_i};

  // Stage 0 .. PIPELINE_NUM-1 registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < PIPELINE_NUM; i++) flag_p[i] <= '0;
    end else begin
      vld_p <= vld_in[PIPELINE_NUM-1:0];
      for (int i = 0; i < PIPELINE_NUM; i++) flag_p[i] <= flag_in[i];
    end
  end

  // A mode may only change when nothing is entering or travelling the pipe.
  assign drain = ~rqst_valid_i && (vld_p == '0);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      active_mode    <= '0;
      pending_mode   <= '0;
      mode_pending_o <= 1'b0;
    end else if (drain) begin
      if (mode_load_i) begin
        active_mode    <= modeSet_i;
        mode_pending_o <= 1'b0;
      end else if (mode_pending_o) begin
        active_mode    <= pending_mode;
        mode_pending_o <= 1'b0;
      end
    end else if (mode_load_i) begin
      pending_mode   <= modeSet_i;
      mode_pending_o <= 1'b1;
    end
  end

  // Count and overflow derive from the very flag vector being presented.
  assign share_rqstFlag_o = flag_p[PIPELINE_NUM-1];
  assign valid_o          = vld_p[PIPELINE_NUM-1];
  assign rqst_cnt_o       = popcount(share_rqstFlag_o);
  assign overflow_o       = (int'(rqst_cnt_o) > GP2_CAPACITY);

endmodule

// File: doc/access_rqst_gen_cfg_pipe.md
ACCESS_RQST_GEN_CFG_PIPE -- requirements
Module: access_rqst_gen_cfg_pipe

Interface
REQ-001 SHALL have parameter SHARED_BANK_NUM, default 5, meaning the number of requestors in the share group.
REQ-002 SHALL have parameter RQST_ADDR_BITWIDTH, default 3, meaning the column-address width per requestor; legal range is 2 or more.
REQ-003 SHALL have parameter MODE_BITWIDTH, default 3, meaning the mode-set width.
REQ-004 SHALL have parameter PIPELINE_NUM, default 1, meaning the input-to-output latency in cycles; legal range is 1 or more.
REQ-005 SHALL have parameter GP2_CAPACITY, default 2, meaning the maximum number of subgroup-2 accesses serviceable per cycle.
REQ-006 SHALL have port sys_clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port rqst_addr_i, input, RQST_ADDR_BITWIDTH*SHARED_BANK_NUM bits: concatenated addresses; requestor i occupies bits [(i+1)*W-1 : i*W].
REQ-009 SHALL have port rqst_valid_i, input, 1 bit: rqst_addr_i is valid this cycle.
REQ-010 SHALL have port modeSet_i, input, MODE_BITWIDTH bits: the requested mode.
REQ-011 SHALL have port mode_load_i, input, 1 bit: single-cycle strobe that captures modeSet_i.
REQ-012 SHALL have port share_rqstFlag_o, output, SHARED_BANK_NUM bits: registered per-requestor subgroup-2 request flags.
REQ-013 SHALL have port rqst_cnt_o, output, $clog2(SHARED_BANK_NUM+1) bits: population count of share_rqstFlag_o.
REQ-014 SHALL have port overflow_o, output, 1 bit: rqst_cnt_o > GP2_CAPACITY.
REQ-015 SHALL have port valid_o, output, 1 bit: the outputs correspond to a valid input.
REQ-016 SHALL have port mode_pending_o, output, 1 bit: a loaded mode is waiting to be applied.

Function
REQ-017 SHALL decode each requestor's address a[1:0] against active_mode as follows:
- 0: a[1]==0
- 1: a[1]==1
- 2: a[0]==0
- 3: a[0]==1
- 4: a[1:0] in {01,10}
- 5: a[1:0] in {00,11}
- 6: a[W-1:2]==0, i.e. address <4; for W=2 this is always true
- 7 and above: flag 0
REQ-018 SHALL decode all requestors in parallel, in the stage-0 register, using the active_mode value at the sampling edge.
REQ-019 SHALL force all flags to 0 for any cycle where rqst_valid_i=0.
REQ-020 SHALL present share_rqstFlag_o, rqst_cnt_o, overflow_o and valid_o exactly PIPELINE_NUM cycles after the sampling edge; the four outputs stay mutually aligned.
REQ-021 SHALL accept a new input every cycle (no backpressure).
REQ-022 SHALL compute rqst_cnt_o and overflow_o from the same flag vector that is output with them, never from a neighbouring stage.
REQ-023 SHALL, on mode_load_i=1, capture modeSet_i into pending_mode and set mode_pending_o=1.
REQ-024 SHALL let a second mode_load_i overwrite pending_mode; last write wins.
REQ-025 SHALL apply pending_mode to active_mode only at a drain edge, defined as rqst_valid_i=0 and no valid in any pipeline stage; mode_pending_o clears on that same edge.
REQ-026 SHALL, when mode_load_i=1 coincides with a drain edge, load modeSet_i directly into active_mode and keep mode_pending_o=0.
REQ-027 SHALL never change the mode of a transaction already in flight.
REQ-028 SHALL, when mode_load_i=1 coincides with rqst_valid_i=1, decode the valid input with the old mode and set the new mode pending.

Reset
REQ-029 SHALL, while rst=1 and regardless of clock, force active_mode=0, pending_mode=0, mode_pending_o=0, all pipeline stages invalid, share_rqstFlag_o=0, rqst_cnt_o=0, overflow_o=0 and valid_o=0.
REQ-030 SHALL discard any in-flight data and any pending mode on a reset asserted mid-operation.
REQ-031 SHALL accept the first input on the first rising edge after rst deasserts.

Verification (defaults; addresses listed for i=0..4 = 0,1,2,3,4)
REQ-032 SHALL cover: reset, then valid input in mode 0 -> one cycle later share_rqstFlag_o=5'b10011, rqst_cnt_o=3, overflow_o=1, valid_o=1.
REQ-033 SHALL cover: mode_load_i with 4 during a drain, then the same input -> share_rqstFlag_o=5'b00110, cnt=2, overflow=0.
REQ-034 SHALL cover: mode_load_i with 6 while rqst_valid_i is held 1 continuously -> mode_pending_o=1 and outputs stay in the old mode; first idle cycle applies it; next input -> 5'b01111, cnt=4.
REQ-035 SHALL cover: rqst_valid_i=0 with arbitrary addresses -> valid_o=0, flags=0, cnt=0 one cycle later.
REQ-036 SHALL cover: PIPELINE_NUM=3 with back-to-back inputs in mode 0 then mode 3 -> per-transaction flags emerge in order 3 cycles late, with no mode mixing.
REQ-037 SHALL cover: rst asserted with 2 transactions in flight and a pending mode -> all outputs 0 asynchronously, mode_pending_o=0, active_mode=0.
